// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared state encodings and counter sizing for uart_link
package uart_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_link_if.sv
// rtl/uart_link_if.sv - packetizer-side send/receive handshake bundle
interface uart_link_if #(
  parameter int PACKET_SIZE = 8
) ();

  logic                   send_flag;
  logic [PACKET_SIZE-1:0] send_data;
  logic                   sendable;
  logic                   recv_flag;
  logic [PACKET_SIZE-1:0] recv_data;
  logic                   receivable;

  modport master (
    output send_flag, send_data, recv_flag,
    input  sendable, recv_data, receivable
  );

  modport slave (
    input  send_flag, send_data, recv_flag,
    output sendable, recv_data, receivable
  );

endinterface

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - synchronous FIFO; pushes into a full FIFO are dropped and flagged
module link_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_head,
  output logic [DEPTH_BITS:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  r_overflow;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full     = (r_count == (DEPTH_BITS+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_head     = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
      // A simultaneous pop does not make room for a push into a full FIFO.
      r_overflow <= i_push && o_full;
    end
  end

endmodule

// File: rtl/uart_link.sv
// rtl/uart_link.sv - buffered 8N1 serial link below the packetizer
module uart_link
  import uart_link_pkg::*;
#(
  parameter int PACKET_SIZE  = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_BIT     = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  uart_link_if.slave pkt,
  input  logic      uart_rx,
  output logic      uart_tx,
  output logic      rx_frame_err,
  output logic      rx_overflow
);

  localparam int CW    = cnt_width(CLKS_PER_BIT);
  localparam int BW    = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
  localparam int DEPTH = 1 << FIFO_BIT;
  localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]     BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]     BIT_LAST  = BW'(PACKET_SIZE - 1);
  localparam logic [FIFO_BIT:0] SEND_MAX  = (FIFO_BIT+1)'(DEPTH - 2);

  tx_state_t              r_tx_state;
  logic [CW-1:0]          r_tx_baud;
  logic [BW-1:0]          r_tx_bit;
  logic [PACKET_SIZE-1:0] r_tx_shreg;
  logic                   r_tx_line;
  rx_state_t              r_rx_state;
  logic [CW-1:0]          r_rx_baud;
  logic [BW-1:0]          r_rx_bit;
  logic [PACKET_SIZE-1:0] r_rx_shreg;
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic                   r_frame_err;

  logic [PACKET_SIZE-1:0] w_tx_head;
  logic [FIFO_BIT:0]      w_tx_count;
  logic                   w_tx_full, w_tx_empty, w_tx_ovf, w_tx_pop;
  logic [FIFO_BIT:0]      w_rx_count;
  logic                   w_rx_full, w_rx_empty, w_rx_ovf, w_rx_push;
  logic                   w_unused;

  // Pop at the end of STOP too, so back-to-back frames have no idle gap.
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) ||
                     (r_tx_state == TX_STOP && r_tx_baud == BAUD_LAST));
  assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_baud == BAUD_LAST) && r_rx_sync;

  link_fifo #(.WIDTH(PACKET_SIZE), .DEPTH_BITS(FIFO_BIT)) u_tx_fifo (
    .clk(CLK), .rst_n(RST_N), .i_push(pkt.send_flag), .i_pop(w_tx_pop),
    .i_din(pkt.send_data), .o_head(w_tx_head), .o_count(w_tx_count),
    .o_full(w_tx_full), .o_empty(w_tx_empty), .o_overflow(w_tx_ovf)
  );

  link_fifo #(.WIDTH(PACKET_SIZE), .DEPTH_BITS(FIFO_BIT)) u_rx_fifo (
    .clk(CLK), .rst_n(RST_N), .i_push(w_rx_push), .i_pop(pkt.recv_flag),
    .i_din(r_rx_shreg), .o_head(pkt.recv_data), .o_count(w_rx_count),
    .o_full(w_rx_full), .o_empty(w_rx_empty), .o_overflow(w_rx_ovf)
  );

  // Margins cover the packetizer's one-cycle registered flags.
  assign pkt.sendable   = (w_tx_count <= SEND_MAX);
  assign pkt.receivable = !w_rx_empty && !pkt.recv_flag;
  assign uart_tx        = r_tx_line;
  assign rx_frame_err   = r_frame_err;
  assign rx_overflow    = w_tx_ovf | w_rx_ovf;
  assign w_unused       = ^{w_tx_full, w_rx_full, w_rx_count};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shreg <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_tx_shreg <= w_tx_head;
            r_tx_line  <= 1'b0;
            r_tx_baud  <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_line  <= r_tx_shreg[0];
            r_tx_shreg <= r_tx_shreg >> 1;
            r_tx_state <= TX_DATA;
          end else r_tx_baud <= r_tx_baud + CW'(1);
        end
        TX_DATA: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud <= '0;
            if (r_tx_bit == BIT_LAST) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + BW'(1);
              r_tx_line  <= r_tx_shreg[0];
              r_tx_shreg <= r_tx_shreg >> 1;
            end
          end else r_tx_baud <= r_tx_baud + CW'(1);
        end
        TX_STOP: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud <= '0;
            if (w_tx_pop) begin
              r_tx_shreg <= w_tx_head;
              r_tx_line  <= 1'b0;
              r_tx_state <= TX_START;
            end else r_tx_state <= TX_IDLE;
          end else r_tx_baud <= r_tx_baud + CW'(1);
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_baud   <= '0;
      r_rx_bit    <= '0;
      r_rx_shreg  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= uart_rx;
      r_rx_sync   <= r_rx_meta;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_baud  <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else r_rx_baud <= r_rx_baud + CW'(1);
        end
        RX_DATA: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_shreg <= {r_rx_sync, r_rx_shreg[PACKET_SIZE-1:1]};
            if (r_rx_bit == BIT_LAST) r_rx_state <= RX_STOP;
            else                      r_rx_bit   <= r_rx_bit + BW'(1);
          end else r_rx_baud <= r_rx_baud + CW'(1);
        end
        RX_STOP: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud <= '0;
            if (r_rx_sync) r_rx_state <= RX_IDLE;
            else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_WAIT_HIGH;
            end
          end else r_rx_baud <= r_rx_baud + CW'(1);
        end
        RX_WAIT_HIGH: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_link.md
# uart_link

Byte-level serial link that sits directly below the multichannel packetizer. It accepts `PACKET_SIZE`-bit symbols through the packetizer's send port and transmits them as 8N1-style UART frames. It deserializes incoming frames and presents them through the packetizer's receive port. Both directions are buffered by FIFOs, and the flow-control outputs tolerate the packetizer's one-cycle registered flag latency.

## Interface
- `PACKET_SIZE`, 8: data bits per frame; matches the packetizer symbol width.
- `CLKS_PER_BIT`, 868: clock cycles per bit time (100 MHz / 115200); must be ≥ 4.
- `FIFO_BIT`, 4: log2 depth of each FIFO (depth 16).

Ports:
- `CLK` input 1: single clock.
- `RST_N` input 1: reset, asynchronous and active-low.
- `send_flag` input 1: push `send_data` into the TX FIFO this cycle.
- `send_data` input `PACKET_SIZE`: symbol to transmit.
- `sendable` output 1: TX FIFO has ≥ 2 free slots.
- `recv_flag` input 1: pop the RX FIFO head this cycle.
- `recv_data` output `PACKET_SIZE`: RX FIFO head; valid while `receivable`.
- `receivable` output 1: RX FIFO non-empty and `recv_flag` low.
- `uart_rx` input 1: serial line in, asynchronous, idles high.
- `uart_tx` output 1: serial line out, idles high.
- `rx_frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `rx_overflow` output 1: one-cycle pulse when a frame, or a push, is dropped because its FIFO is full.

## Operation
- **Flow-control margin.** The packetizer registers its flags, so it may push one cycle after it last saw `sendable`.
  - `sendable` = free ≥ 2, which guarantees room for the in-flight push.
  - `receivable` is masked while `recv_flag` is high, so the same head is never consumed twice. Throughput is one symbol per 2 cycles.
- **Push to a full TX FIFO.** The symbol is dropped and `rx_overflow` pulses. This is an illegal use and is flagged for the bench.
- **TX FSM.**
  - States: IDLE, START, DATA, STOP. A baud counter runs 0..`CLKS_PER_BIT`-1.
  - IDLE → START when the TX FIFO is non-empty. The head is popped into a shift register and `uart_tx` goes 0.
  - START → DATA after one bit time.
  - DATA shifts out LSB first, `PACKET_SIZE` bits, one bit time each, tracked by a bit counter.
  - DATA → STOP: `uart_tx` = 1 for one bit time.
  - STOP → IDLE, or directly to START if the FIFO is non-empty. There are no extra idle bits between frames.
- **RX synchronizer.** `uart_rx` passes through a 2-flop synchronizer.
- **RX FSM.**
  - States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE → START on synchronized line = 0.
  - In START, the line is sampled at `CLKS_PER_BIT`/2. If it is 1 (false start), return to IDLE. If it is 0, go to DATA.
  - DATA samples each bit at mid-bit, every `CLKS_PER_BIT` cycles, LSB first.
  - In STOP, the line is sampled at mid-bit:
    - Line = 1: push the symbol to the RX FIFO, or drop it with an `rx_overflow` pulse if full. Go to IDLE.
    - Line = 0: pulse `rx_frame_err`, discard the symbol, and go to WAIT_HIGH.
  - WAIT_HIGH → IDLE when the line is 1.
- **Simultaneous push and pop on one FIFO.** Both take effect and the count is unchanged. A push when full is dropped even with a simultaneous pop.
- **Pointers** wrap modulo 2^`FIFO_BIT`. The count is `FIFO_BIT`+1 bits wide.

## Timing
- **Reset values:**
  - `uart_tx` = 1, `sendable` = 1, `receivable` = 0, `recv_data` = 0.
  - Error pulses 0, FIFOs empty, both FSMs IDLE, counters 0.
- **Reset mid-frame** aborts immediately: `uart_tx` returns to 1 asynchronously and the partial RX symbol is lost.
- **TX latency.** With `send_flag` high in cycle t, the symbol is in the FIFO after edge t+1 and `uart_tx` falls at edge t+2 (TX idle).
- **TX frame** is (`PACKET_SIZE`+2)·`CLKS_PER_BIT` cycles.
- **RX latency.**
  - The synchronizer adds 2 cycles.
  - The push occurs on the edge of the stop-bit mid-sample.
  - `receivable` rises the following cycle.
- **`recv_data`** is combinational from the FIFO head and changes the cycle after a pop.

## Structure
- **Shared package `uart_link_pkg`:** TX/RX state encodings and the baud/bit counter width function (`$clog2(CLKS_PER_BIT)`).
- **Sub-module `link_fifo`:** a synchronous FIFO instantiated twice.
  - Parameters: width, depth bits.
  - Ports: push, pop, data in, head, count, full, empty, and an overflow pulse.
- All remaining logic (the two FSMs and the synchronizer) lives in `uart_link`.

## Test plan
Bench uses `CLKS_PER_BIT`=4 and defaults otherwise.

1. **Single TX frame.** Push 0xA5 once. `uart_tx` shows 0,1,0,1,0,0,1,0,1,1 at 4-cycle steps, starting 2 cycles after the push.
2. **TX back-pressure.** Push 20 symbols whenever `sendable` (flag registered one cycle late). No drops and no `rx_overflow`; all 20 emerge in order. `sendable` is low when 15 slots are used.
3. **RX loopback.** Tie `uart_tx` to `uart_rx` and send 0x00, 0xFF, 0x3C. `recv_data` yields the same three symbols. `receivable` never stays high during a cycle in which `recv_flag` is high.
4. **Framing and false start.**
   - Drive a 1-cycle low glitch: no symbol.
   - Drive a frame with stop bit 0: `rx_frame_err` pulses once, the RX FIFO stays empty, and the next valid frame 0x5A is received.
5. **RX overflow.** Receive 17 frames without popping. 16 are stored, `rx_overflow` pulses once, and the first 16 symbols pop in order.
6. **Reset mid-frame.** Assert `RST_N`=0 during DATA of a TX frame and of an RX frame. `uart_tx` goes 1 immediately, `receivable`=0, and `sendable`=1. A post-reset frame 0x81 transfers correctly.
